// File: rtl/snake_game_ctrl.sv
// Game-control stage of the snake game: start-key debounce, START/PLAY/END FSM,
// eat/collision detection, score pulse generation and LFSR-driven apple relocation.
//
// state    | meaning
// ST_START | waiting for a start press, head updates ignored
// ST_PLAY  | game running, eat/collision evaluated on every Head_valid
// ST_END   | game over, waiting for a press to return to START
// P_IDLE   | no score pulse in flight
// P_HIGH   | Body_add_sig asserted for ADD_PULSE_CYCLES
// P_GAP    | enforced low time before another pulse may start
module snake_game_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES  = 1_000_000,
    parameter int unsigned ADD_PULSE_CYCLES = 16,
    parameter int unsigned GRID_W           = 40,
    parameter int unsigned GRID_H           = 30
) (
    input  logic       Clk_50mhz,
    input  logic       Rst,
    input  logic       Key_start,
    input  logic       Head_valid,
    input  logic [5:0] Head_x,
    input  logic [5:0] Head_y,
    input  logic       Hit_wall,
    input  logic       Hit_body,
    output logic [2:0] Game_status,
    output logic       Body_add_sig,
    output logic [5:0] Apple_x,
    output logic [5:0] Apple_y,
    output logic       Apple_valid
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int P_W  = (ADD_PULSE_CYCLES > 1) ? $clog2(ADD_PULSE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LOAD = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [P_W-1:0]  P_LOAD  = P_W'(ADD_PULSE_CYCLES - 1);
    localparam logic [15:0]     LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        ST_START = 3'b001,
        ST_PLAY  = 3'b010,
        ST_END   = 3'b100
    } game_state_t;

    typedef enum logic [1:0] {
        P_IDLE = 2'd0,
        P_HIGH = 2'd1,
        P_GAP  = 2'd2
    } pulse_state_t;

    logic            key_meta_q, key_sync_q;
    logic            key_level_q, key_level_d;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            press_q, press_d;

    game_state_t     state_q, state_d;
    pulse_state_t    pst_q, pst_d;
    logic [P_W-1:0]  pcnt_q, pcnt_d;
    logic            pend_q, pend_d;
    logic            body_q;

    logic [15:0]     lfsr_q, lfsr_d;
    logic [5:0]      last_hx_q, last_hy_q;
    logic [5:0]      apple_x_q, apple_x_d, apple_y_q, apple_y_d;
    logic            apple_valid_q, apple_valid_d;

    logic            collide, eat;
    logic            eat_req, reloc_start, leave_play;
    logic [5:0]      cand_x, cand_y;
    logic            cand_ok;

    // Start key: synchronise, then accept a level only after it has been stable long enough.
    always_comb begin
        key_level_d = key_level_q;
        db_cnt_d    = DB_LOAD;
        press_d     = 1'b0;
        if (key_sync_q != key_level_q) begin
            if (db_cnt_q == '0) begin
                key_level_d = key_sync_q;
                press_d     = ~key_sync_q;
            end else begin
                db_cnt_d = db_cnt_q - DB_W'(1);
            end
        end
    end

    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            key_meta_q  <= 1'b1;
            key_sync_q  <= 1'b1;
            key_level_q <= 1'b1;
            db_cnt_q    <= DB_LOAD;
            press_q     <= 1'b0;
        end else begin
            key_meta_q  <= Key_start;
            key_sync_q  <= key_meta_q;
            key_level_q <= key_level_d;
            db_cnt_q    <= db_cnt_d;
            press_q     <= press_d;
        end
    end

    assign collide = Head_valid & (Hit_wall | Hit_body);
    assign eat     = Head_valid & ~Hit_wall & ~Hit_body & apple_valid_q &
                     (Head_x == apple_x_q) & (Head_y == apple_y_q);

    always_comb begin
        state_d     = state_q;
        reloc_start = 1'b0;
        eat_req     = 1'b0;
        leave_play  = 1'b0;
        unique case (state_q)
            ST_START: begin
                if (press_q) begin
                    state_d     = ST_PLAY;
                    reloc_start = 1'b1;
                end
            end
            ST_PLAY: begin
                if (collide) begin
                    state_d    = ST_END;
                    leave_play = 1'b1;
                end else if (eat) begin
                    eat_req     = 1'b1;
                    reloc_start = 1'b1;
                end
            end
            ST_END: begin
                if (press_q) state_d = ST_START;
            end
            default: state_d = ST_START;
        endcase
    end

    // A request at GAP expiry (pending or fresh) goes straight to HIGH so the low gap is exact.
    always_comb begin
        pst_d  = pst_q;
        pcnt_d = pcnt_q;
        pend_d = pend_q;
        unique case (pst_q)
            P_IDLE: begin
                if (eat_req) begin
                    pst_d  = P_HIGH;
                    pcnt_d = P_LOAD;
                end
            end
            P_HIGH: begin
                if (eat_req) pend_d = 1'b1;
                if (pcnt_q == '0) begin
                    pst_d  = P_GAP;
                    pcnt_d = P_LOAD;
                end else begin
                    pcnt_d = pcnt_q - P_W'(1);
                end
            end
            P_GAP: begin
                if (pcnt_q == '0) begin
                    pcnt_d = P_LOAD;
                    if ((pend_q && !leave_play) || eat_req) begin
                        pst_d  = P_HIGH;
                        pend_d = 1'b0;
                    end else begin
                        pst_d = P_IDLE;
                    end
                end else begin
                    if (eat_req) pend_d = 1'b1;
                    pcnt_d = pcnt_q - P_W'(1);
                end
            end
            default: begin
                pst_d  = P_IDLE;
                pcnt_d = P_LOAD;
                pend_d = 1'b0;
            end
        endcase
        if (leave_play) pend_d = 1'b0;
    end

    assign lfsr_d  = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign cand_x  = lfsr_q[5:0];
    assign cand_y  = lfsr_q[11:6];
    assign cand_ok = ({1'b0, cand_x} < 7'(GRID_W)) && ({1'b0, cand_y} < 7'(GRID_H)) &&
                     !((cand_x == last_hx_q) && (cand_y == last_hy_q));

    always_comb begin
        apple_x_d     = apple_x_q;
        apple_y_d     = apple_y_q;
        apple_valid_d = apple_valid_q;
        if (reloc_start) begin
            apple_valid_d = 1'b0;
        end else if (!apple_valid_q && cand_ok) begin
            apple_x_d     = cand_x;
            apple_y_d     = cand_y;
            apple_valid_d = 1'b1;
        end
    end

    always_ff @(posedge Clk_50mhz or posedge Rst) begin
        if (Rst) begin
            state_q       <= ST_START;
            pst_q         <= P_IDLE;
            pcnt_q        <= P_LOAD;
            pend_q        <= 1'b0;
            body_q        <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            last_hx_q     <= '0;
            last_hy_q     <= '0;
            apple_x_q     <= 6'd10;
            apple_y_q     <= 6'd10;
            apple_valid_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            pst_q         <= pst_d;
            pcnt_q        <= pcnt_d;
            pend_q        <= pend_d;
            body_q        <= (pst_d == P_HIGH);
            lfsr_q        <= lfsr_d;
            apple_x_q     <= apple_x_d;
            apple_y_q     <= apple_y_d;
            apple_valid_q <= apple_valid_d;
            if (Head_valid) begin
                last_hx_q <= Head_x;
                last_hy_q <= Head_y;
            end
        end
    end

    assign Game_status  = state_q;
    assign Body_add_sig = body_q;
    assign Apple_x      = apple_x_q;
    assign Apple_y      = apple_y_q;
    assign Apple_valid  = apple_valid_q;

endmodule
